// File: rtl/mcont_chnbuf_pkg.sv
// Shared types and defaults for the channel-buffer read sequencer.
// The abort feature is enabled by the MCONT_CHNBUF_ABORT_EN macro.
package mcont_chnbuf_pkg;

    localparam int DEF_CHN_WIDTH  = 4;
    localparam int DEF_ADDR_WIDTH = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_READ  = 3'd2,
        ST_PAGE  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // Clamp a requested word count to one full page.
    function automatic int unsigned sat_len(input int unsigned len, input int unsigned addr_width);
        int unsigned full;
        full = 32'd1 << addr_width;
        return (len > full) ? full : len;
    endfunction

endpackage

// File: rtl/mcont_chnbuf_rd_sequencer_if.sv
// Command and buffer-read bundle between the sequencer and the channel buffers.
// The abort input exists only when MCONT_CHNBUF_ABORT_EN is defined.
interface mcont_chnbuf_rd_sequencer_if
    import mcont_chnbuf_pkg::*;
#(
    parameter int CHN_WIDTH  = DEF_CHN_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  start;
    logic [CHN_WIDTH-1:0]  start_chn;
    logic [ADDR_WIDTH:0]   start_len;
    logic                  start_pgnxt;
`ifdef MCONT_CHNBUF_ABORT_EN
    logic                  abort;
`endif
    logic                  busy;
    logic [CHN_WIDTH-1:0]  ext_buf_rchn;
    logic                  ext_buf_rd;
    logic [ADDR_WIDTH-1:0] ext_buf_raddr;
    logic                  ext_buf_rpage_nxt;
    logic                  seq_done;

    modport master (
        input  start, start_chn, start_len, start_pgnxt,
`ifdef MCONT_CHNBUF_ABORT_EN
        input  abort,
`endif
        output busy, ext_buf_rchn, ext_buf_rd, ext_buf_raddr, ext_buf_rpage_nxt, seq_done
    );

    modport slave (
        output start, start_chn, start_len, start_pgnxt,
`ifdef MCONT_CHNBUF_ABORT_EN
        output abort,
`endif
        input  busy, ext_buf_rchn, ext_buf_rd, ext_buf_raddr, ext_buf_rpage_nxt, seq_done
    );

endinterface

// File: rtl/mcont_chnbuf_rd_sequencer.sv
// Channel-buffer read sequencer: channel select, read burst, optional page advance, done pulse.
// Defining MCONT_CHNBUF_ABORT_EN adds an abort input that cuts SETUP/READ short to DONE.
module mcont_chnbuf_rd_sequencer
    import mcont_chnbuf_pkg::*;
#(
    parameter int CHN_WIDTH  = DEF_CHN_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mcont_chnbuf_rd_sequencer_if.master bus
);

    localparam int LEN_W = ADDR_WIDTH + 1;

    seq_state_e            state;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt;
    logic                  pgnxt_q;
    logic                  busy_q;
    logic [CHN_WIDTH-1:0]  rchn_q;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic                  rpage_q;
    logic                  done_q;
    logic                  abort_w;

`ifdef MCONT_CHNBUF_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    // NOTE: every state bit and output register here is assigned with <= so all of them
    // update together on the edge; mixing in blocking writes would make order matter.
    // NOTE: the async reset clears every strobe at once, so a sequence cut by reset
    // never emits a late seq_done or rpage_nxt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            cnt     <= '0;
            pgnxt_q <= 1'b0;
            busy_q  <= 1'b0;
            rchn_q  <= '0;
            rd_q    <= 1'b0;
            raddr_q <= '0;
            rpage_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state   <= ST_SETUP;
                        busy_q  <= 1'b1;
                        rchn_q  <= bus.start_chn;
                        len_q   <= LEN_W'(sat_len(32'(bus.start_len), ADDR_WIDTH));
                        pgnxt_q <= bus.start_pgnxt;
                        cnt     <= '0;
                    end
                end
                ST_SETUP: begin
                    if (abort_w) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else if (len_q != '0) begin
                        state   <= ST_READ;
                        rd_q    <= 1'b1;
                        raddr_q <= '0;
                        cnt     <= LEN_W'(1);
                    end else begin
                        state   <= ST_PAGE;
                        rpage_q <= pgnxt_q;
                    end
                end
                ST_READ: begin
                    if (abort_w) begin
                        state  <= ST_DONE;
                        rd_q   <= 1'b0;
                        done_q <= 1'b1;
                    end else if (cnt == len_q) begin
                        state   <= ST_PAGE;
                        rd_q    <= 1'b0;
                        rpage_q <= pgnxt_q;
                    end else begin
                        // cnt holds the number of reads already issued, i.e. the next address
                        raddr_q <= cnt[ADDR_WIDTH-1:0];
                        cnt     <= cnt + LEN_W'(1);
                    end
                end
                ST_PAGE: begin
                    state   <= ST_DONE;
                    rpage_q <= 1'b0;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy              = busy_q;
    assign bus.ext_buf_rchn      = rchn_q;
    assign bus.ext_buf_rd        = rd_q;
    assign bus.ext_buf_raddr     = raddr_q;
    assign bus.ext_buf_rpage_nxt = rpage_q;
    assign bus.seq_done          = done_q;

endmodule

// File: tb/tb_mcont_chnbuf_rd_sequencer.sv
// Directed bench for mcont_chnbuf_rd_sequencer; abort case runs when MCONT_CHNBUF_ABORT_EN is defined.
module tb_mcont_chnbuf_rd_sequencer;
    import mcont_chnbuf_pkg::*;

    localparam int CW = 4;
    localparam int AW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mcont_chnbuf_rd_sequencer_if #(.CHN_WIDTH(CW), .ADDR_WIDTH(AW)) bus();

    mcont_chnbuf_rd_sequencer #(.CHN_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // rd, rpage_nxt and seq_done must never overlap
    always @(negedge clk) begin
        if (rst_n)
            check("strobe_overlap",
                  32'($countones({bus.ext_buf_rd, bus.ext_buf_rpage_nxt, bus.seq_done}) > 1), 32'd0);
    end

    typedef struct {
        logic          start;
        logic [CW-1:0] chn;
        logic [AW:0]   len;
        logic          pg;
        logic          busy;
        logic [CW-1:0] rchn;
        logic          rd;
        logic [AW-1:0] raddr;
        logic          rpage;
        logic          done;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [CW-1:0] c, input logic [AW:0] l,
                                input logic p, input logic b, input logic [CW-1:0] rc,
                                input logic rd, input logic [AW-1:0] ra, input logic rp,
                                input logic d);
        vec_t v;
        v.start = s;  v.chn = c;   v.len = l;  v.pg = p;
        v.busy  = b;  v.rchn = rc; v.rd = rd;  v.raddr = ra;
        v.rpage = rp; v.done = d;
        return v;
    endfunction

    task automatic drive(input logic s, input logic [CW-1:0] c, input logic [AW:0] l, input logic p);
        bus.start       = s;
        bus.start_chn   = c;
        bus.start_len   = l;
        bus.start_pgnxt = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_rchn"},  32'(bus.ext_buf_rchn), 32'd0);
        check({tag, "_rd"},    32'(bus.ext_buf_rd), 32'd0);
        check({tag, "_raddr"}, 32'(bus.ext_buf_raddr), 32'd0);
        check({tag, "_rpage"}, 32'(bus.ext_buf_rpage_nxt), 32'd0);
        check({tag, "_done"},  32'(bus.seq_done), 32'd0);
    endtask

    // Full-page burst: expects 64 reads regardless of a saturating requested length.
    task automatic run_long(input logic [AW:0] len_in, input logic [CW-1:0] chn);
        drive(1'b1, chn, len_in, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("long_setup_rd", 32'(bus.ext_buf_rd), 32'd0);
        check("long_setup_rchn", 32'(bus.ext_buf_rchn), 32'(chn));
        tick();
        for (int i = 0; i < 64; i++) begin
            check("long_rd", 32'(bus.ext_buf_rd), 32'd1);
            check("long_raddr", 32'(bus.ext_buf_raddr), 32'(i));
            tick();
        end
        check("long_rd_end", 32'(bus.ext_buf_rd), 32'd0);
        check("long_rpage", 32'(bus.ext_buf_rpage_nxt), 32'd1);
        tick();
        check("long_done", 32'(bus.seq_done), 32'd1);
        tick();
        check("long_idle_busy", 32'(bus.busy), 32'd0);
    endtask

    vec_t vt[17];

    initial begin
        int rds;
        int k;

        // chn5/len4/pg1, back-to-back len0/pg0, then len0/pg1
        vt[0]  = mk(1, 5, 4, 1,  0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0,  1, 5, 0, 0, 0, 0);
        vt[2]  = mk(0, 0, 0, 0,  1, 5, 1, 0, 0, 0);
        vt[3]  = mk(0, 0, 0, 0,  1, 5, 1, 1, 0, 0);
        vt[4]  = mk(0, 0, 0, 0,  1, 5, 1, 2, 0, 0);
        vt[5]  = mk(0, 0, 0, 0,  1, 5, 1, 3, 0, 0);
        vt[6]  = mk(0, 0, 0, 0,  1, 5, 0, 0, 1, 0);
        vt[7]  = mk(0, 0, 0, 0,  1, 5, 0, 0, 0, 1);
        vt[8]  = mk(1, 9, 0, 0,  0, 5, 0, 0, 0, 0);
        vt[9]  = mk(0, 0, 0, 0,  1, 9, 0, 0, 0, 0);
        vt[10] = mk(0, 0, 0, 0,  1, 9, 0, 0, 0, 0);
        vt[11] = mk(0, 0, 0, 0,  1, 9, 0, 0, 0, 1);
        vt[12] = mk(1, 3, 0, 1,  0, 9, 0, 0, 0, 0);
        vt[13] = mk(0, 0, 0, 0,  1, 3, 0, 0, 0, 0);
        vt[14] = mk(0, 0, 0, 0,  1, 3, 0, 0, 1, 0);
        vt[15] = mk(0, 0, 0, 0,  1, 3, 0, 0, 0, 1);
        vt[16] = mk(0, 0, 0, 0,  0, 3, 0, 0, 0, 0);

        drive(1'b0, '0, '0, 1'b0);
`ifdef MCONT_CHNBUF_ABORT_EN
        bus.abort = 1'b0;
`endif
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven traces
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].start, vt[i].chn, vt[i].len, vt[i].pg);
            check("tbl_busy",  32'(bus.busy), 32'(vt[i].busy));
            check("tbl_rchn",  32'(bus.ext_buf_rchn), 32'(vt[i].rchn));
            check("tbl_rd",    32'(bus.ext_buf_rd), 32'(vt[i].rd));
            if (vt[i].rd)
                check("tbl_raddr", 32'(bus.ext_buf_raddr), 32'(vt[i].raddr));
            check("tbl_rpage", 32'(bus.ext_buf_rpage_nxt), 32'(vt[i].rpage));
            check("tbl_done",  32'(bus.seq_done), 32'(vt[i].done));
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);

        // Full page and saturated length
        run_long(7'd64, 4'd12);
        run_long(7'd100, 4'd13);

        // Start during READ is ignored, start right after seq_done is accepted
        drive(1'b1, 4'd2, 7'd6, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        drive(1'b1, 4'd7, 7'd1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("ign_rchn", 32'(bus.ext_buf_rchn), 32'd2);
        check("ign_rd", 32'(bus.ext_buf_rd), 32'd1);
        check("ign_raddr", 32'(bus.ext_buf_raddr), 32'd2);
        rds = 0;
        k = 0;
        while (!bus.seq_done && k < 20) begin
            if (bus.ext_buf_rd) rds++;
            k++;
            tick();
        end
        check("ign_rd_count", 32'(rds), 32'd4);
        check("ign_done_cycle", 32'(k), 32'd5);
        tick();
        check("ign_not_queued", 32'(bus.busy), 32'd0);
        drive(1'b1, 4'd11, 7'd1, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_rchn", 32'(bus.ext_buf_rchn), 32'd11);
        tick();
        check("b2b_rd", 32'(bus.ext_buf_rd), 32'd1);
        tick();
        tick();
        check("b2b_done", 32'(bus.seq_done), 32'd1);
        tick();
        tick();
        check("b2b_idle", 32'(bus.busy), 32'd0);

        // Reset at the 2nd read cycle
        drive(1'b1, 4'd6, 7'd4, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        check("rst_pre_raddr", 32'(bus.ext_buf_raddr), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        #2;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("rst_post_done", 32'(bus.seq_done), 32'd0);
            check("rst_post_rpage", 32'(bus.ext_buf_rpage_nxt), 32'd0);
            check("rst_post_busy", 32'(bus.busy), 32'd0);
            tick();
        end

`ifdef MCONT_CHNBUF_ABORT_EN
        // Abort at the 3rd read of a len=8 burst
        drive(1'b1, 4'd4, 7'd8, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        tick();
        check("abort_rd3", 32'(bus.ext_buf_rd), 32'd1);
        check("abort_raddr3", 32'(bus.ext_buf_raddr), 32'd2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_rd_drop", 32'(bus.ext_buf_rd), 32'd0);
        check("abort_rpage", 32'(bus.ext_buf_rpage_nxt), 32'd0);
        check("abort_done", 32'(bus.seq_done), 32'd1);
        tick();
        check("abort_done_once", 32'(bus.seq_done), 32'd0);
        check("abort_idle", 32'(bus.busy), 32'd0);
        check("abort_no_rpage", 32'(bus.ext_buf_rpage_nxt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
